// File: rtl/time_count_pkg.sv
// Shared constants, count-direction enum and range helpers for the time counter.
package time_count_pkg;

  localparam int unsigned FIELD_W      = 6;
  localparam int unsigned DEF_SEC_MOD  = 60;
  localparam int unsigned DEF_MIN_MOD  = 60;
  localparam int unsigned DEF_HOUR_MOD = 24;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Highest legal value of a field with modulus m.
  function automatic logic [FIELD_W-1:0] mod_max(input int unsigned m);
    return FIELD_W'(m - 1);
  endfunction

  function automatic logic in_range(input logic [FIELD_W-1:0] v, input int unsigned m);
    return 32'(v) < m;
  endfunction

endpackage

// File: rtl/time_digit_cnt.sv
// Generic modulo-MOD up/down counter field with load, carry/borrow in and
// combinational carry/borrow out so a chain of fields ripples in one edge.
module time_digit_cnt
  import time_count_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [FIELD_W-1:0] load_val_i,
  input  logic               cin_i,
  input  dir_e               dir_i,
  output logic [FIELD_W-1:0] cnt_o,
  output logic [FIELD_W-1:0] cnt_nxt_c,
  output logic               cout_c
);

  logic [FIELD_W-1:0] cnt_q, cnt_d;
  logic               at_end_c;

  // Next value: load wins over a step; the step wraps at the direction's end.
  always_comb begin
    cnt_d    = cnt_q;
    cout_c   = 1'b0;
    at_end_c = (dir_i == DIR_DOWN) ? (cnt_q == '0) : (cnt_q == mod_max(MOD));
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cin_i) begin
      cout_c = at_end_c;
      if (dir_i == DIR_DOWN) begin
        cnt_d = at_end_c ? mod_max(MOD) : cnt_q - FIELD_W'(1);
      end else begin
        cnt_d = at_end_c ? '0 : cnt_q + FIELD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_c = cnt_d;

endmodule

// File: rtl/time_count_core.sv
// Hours:minutes:seconds up/down counter with validated preset load and wrap strobes.
// Optional alarm compare enabled by defining TIME_COUNT_ALARM_EN.
module time_count_core
  import time_count_pkg::*;
#(
  parameter int unsigned SEC_MOD  = DEF_SEC_MOD,
  parameter int unsigned MIN_MOD  = DEF_MIN_MOD,
  parameter int unsigned HOUR_MOD = DEF_HOUR_MOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               dir,
  input  logic               pause,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_sec,
  input  logic [FIELD_W-1:0] load_min,
  input  logic [FIELD_W-1:0] load_hour,
  output logic [FIELD_W-1:0] second,
  output logic [FIELD_W-1:0] minute,
  output logic [FIELD_W-1:0] hour,
  output logic               min_stb,
  output logic               hour_stb,
  output logic               day_stb,
  output logic               load_err
`ifdef TIME_COUNT_ALARM_EN
  ,
  input  logic               alarm_set,
  input  logic [FIELD_W-1:0] alarm_sec,
  input  logic [FIELD_W-1:0] alarm_min,
  input  logic [FIELD_W-1:0] alarm_hour,
  output logic               alarm_stb
`endif
);

  logic               load_ok_c, load_acc_c, tick_acc_c;
  logic               sec_cout_c, min_cout_c, hour_cout_c;
  logic [FIELD_W-1:0] sec_nxt_c, min_nxt_c, hour_nxt_c;
  logic               min_stb_q, hour_stb_q, day_stb_q, load_err_q;
  dir_e               dir_c;

  // Load beats pause beats tick; a rejected load still swallows the tick.
  assign load_ok_c  = in_range(load_sec, SEC_MOD) && in_range(load_min, MIN_MOD) &&
                      in_range(load_hour, HOUR_MOD);
  assign load_acc_c = load && load_ok_c;
  assign tick_acc_c = tick && !load && !pause;
  assign dir_c      = dir_e'(dir);

  time_digit_cnt #(.MOD(SEC_MOD)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_acc_c),
    .load_val_i (load_sec),
    .cin_i      (tick_acc_c),
    .dir_i      (dir_c),
    .cnt_o      (second),
    .cnt_nxt_c  (sec_nxt_c),
    .cout_c     (sec_cout_c)
  );

  time_digit_cnt #(.MOD(MIN_MOD)) u_min (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_acc_c),
    .load_val_i (load_min),
    .cin_i      (sec_cout_c),
    .dir_i      (dir_c),
    .cnt_o      (minute),
    .cnt_nxt_c  (min_nxt_c),
    .cout_c     (min_cout_c)
  );

  time_digit_cnt #(.MOD(HOUR_MOD)) u_hour (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_acc_c),
    .load_val_i (load_hour),
    .cin_i      (min_cout_c),
    .dir_i      (dir_c),
    .cnt_o      (hour),
    .cnt_nxt_c  (hour_nxt_c),
    .cout_c     (hour_cout_c)
  );

  // Strobes line up with the first cycle the wrapped count is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_stb_q  <= 1'b0;
      hour_stb_q <= 1'b0;
      day_stb_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      min_stb_q  <= sec_cout_c;
      hour_stb_q <= min_cout_c;
      day_stb_q  <= hour_cout_c;
      load_err_q <= load && !load_ok_c;
    end
  end

  assign min_stb  = min_stb_q;
  assign hour_stb = hour_stb_q;
  assign day_stb  = day_stb_q;
  assign load_err = load_err_q;

`ifdef TIME_COUNT_ALARM_EN
  logic [FIELD_W-1:0] alarm_sec_q, alarm_min_q, alarm_hour_q;
  logic               alarm_stb_q, alarm_hit_c;

  // Match against the value the counters are about to take.
  assign alarm_hit_c = (tick_acc_c || load_acc_c) && (sec_nxt_c == alarm_sec_q) &&
                       (min_nxt_c == alarm_min_q) && (hour_nxt_c == alarm_hour_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_sec_q  <= '0;
      alarm_min_q  <= '0;
      alarm_hour_q <= '0;
      alarm_stb_q  <= 1'b0;
    end else begin
      if (alarm_set) begin
        alarm_sec_q  <= alarm_sec;
        alarm_min_q  <= alarm_min;
        alarm_hour_q <= alarm_hour;
      end
      alarm_stb_q <= alarm_hit_c;
    end
  end

  assign alarm_stb = alarm_stb_q;
`else
  // Next-state values only feed the alarm compare.
  logic [3*FIELD_W-1:0] nxt_unused;
  assign nxt_unused = {hour_nxt_c, min_nxt_c, sec_nxt_c};
`endif

endmodule
